// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RV32I fetch front end.
//   - XLEN               : architectural address/data width
//   - OPC_*              : major opcodes the decoder implements
//   - fetch_entry_t      : one instruction-buffer entry {instr, pc[, illegal]}
//   - opcode_supported() : true when the decoder has a path for an opcode
//   Optional feature macro: FETCH_ILLEGAL_CHECK_EN adds the per-entry
//   'illegal' flag to fetch_entry_t.
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
`ifdef FETCH_ILLEGAL_CHECK_EN
      logic            illegal;
`endif
   } fetch_entry_t;

   // Opcodes outside this set would fall into the decoder's default path.
   function automatic logic opcode_supported(input logic [6:0] opc);
      return (opc == OPC_LOAD)   || (opc == OPC_STORE) || (opc == OPC_OP) ||
             (opc == OPC_BRANCH) || (opc == OPC_JAL);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO of fetch_entry_t used as the instruction buffer.
//   Storage is plain flops reset to zero so the head reads as all-zero out
//   of reset. Flush has priority over push and pop.
// Ports
//   clk        in   core clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   drop all entries (pointers and count to zero)
//   push       in   write push_data at the tail (never asserted when full)
//   push_data  in   entry to write
//   pop        in   advance the head (never asserted when empty)
//   head       out  entry at the head (registered storage)
//   count      out  number of valid entries
//   empty      out  count == 0
// -----------------------------------------------------------------------------
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            // DEPTH is a power of two, so the pointers wrap naturally.
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   RV32I fetch front end: PC generation, instruction-memory requests,
//   instruction buffering and valid/ready hand-off to decode. A redirect from
//   execute flushes the buffer and retargets the PC; a one-bit epoch tag on
//   the outstanding request discards any stale response.
// Parameters
//   XLEN        address/data width (must match riscv_pkg::XLEN)
//   RESET_PC    PC of the first fetch after reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req / imem_addr        read request and word-aligned address
//   imem_rdata                  read data, one cycle after imem_req
//   redirect_valid/redirect_pc  PC change from execute (pc[1:0] ignored)
//   instr_valid / instr_ready   decode handshake
//   instr / instr_pc            buffered instruction word and its address
//   instr_illegal               unsupported opcode flag for the head entry
// Optional feature macro: FETCH_ILLEGAL_CHECK_EN enables instr_illegal;
//   when undefined instr_illegal is tied to 0 and no flag is stored.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_illegal
);

   import riscv_pkg::*;

   localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0]  DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  tag_pc_q, tag_pc_d;
   logic             epoch_q, epoch_d;
   logic             inflight_q, inflight_d;
   logic             tag_epoch_q, tag_epoch_d;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;
   logic [CNT_W:0]   occupancy;
   logic             req_core;

   // Low address bits of a redirect target are discarded by design.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   always_comb begin
      // A redirect overrides the pop, so the head is not consumed that cycle.
      fifo_pop = !fifo_empty && instr_ready && !redirect_valid;

      // Slots that will be occupied after this edge if a request is issued.
      // The slot freed by a same-cycle pop is counted as available, which
      // is what lets a 2-entry buffer sustain one instruction per cycle;
      // a push still never lands in a full buffer.
      occupancy = {1'b0, fifo_count}
                - {{CNT_W{1'b0}}, fifo_pop}
                + {{CNT_W{1'b0}}, inflight_q};
      req_core  = !redirect_valid && (occupancy < DEPTH_OCC);

      // Response returns the cycle after the request; stale epochs are
      // dropped, and a redirect this cycle flushes regardless.
      fifo_push = inflight_q && (tag_epoch_q == epoch_q) && !redirect_valid;

      push_entry       = '0;
      push_entry.instr = imem_rdata[31:0];
      push_entry.pc    = tag_pc_q;
`ifdef FETCH_ILLEGAL_CHECK_EN
      push_entry.illegal = !opcode_supported(imem_rdata[6:0]);
`endif
   end

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      epoch_d     = epoch_q;
      inflight_d  = req_core;
      tag_epoch_d = tag_epoch_q;
      tag_pc_d    = tag_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         epoch_d    = !epoch_q;
      end else if (req_core) begin
         fetch_pc_d  = fetch_pc_q + XLEN'(4);
         tag_epoch_d = epoch_q;
         tag_pc_d    = fetch_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q  <= RESET_PC;
         epoch_q     <= 1'b0;
         inflight_q  <= 1'b0;
         tag_epoch_q <= 1'b0;
         tag_pc_q    <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         epoch_q     <= epoch_d;
         inflight_q  <= inflight_d;
         tag_epoch_q <= tag_epoch_d;
         tag_pc_q    <= tag_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .head      (head_entry),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // Request is held low while reset is asserted.
   assign imem_req    = rst_n && req_core;
   assign imem_addr   = fetch_pc_q;
   assign instr_valid = !fifo_empty;
   assign instr       = head_entry.instr;
   assign instr_pc    = head_entry.pc;
`ifdef FETCH_ILLEGAL_CHECK_EN
   assign instr_illegal = head_entry.illegal;
`else
   assign instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

`ifdef FETCH_ILLEGAL_CHECK_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_illegal;

   instr_fetch_unit #(
      .XLEN       (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_illegal  (instr_illegal)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;
   logic [31:0] exp_q[$];

   typedef struct packed {
      logic [31:0] target;
      logic [31:0] exp_pc;
      logic [31:0] exp_word;
      logic        exp_ill;
      logic        rnd_ready;
   } vec_t;

   vec_t vecs [8];
   vec_t bb_vec;

   // Instruction memory contents: address as data except a few real encodings.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0300: return 32'h0000_0013; // addi (OP-IMM)
         32'h0000_0304: return 32'h00B5_0533; // add
         32'h0000_0308: return 32'h0000_2003; // lw
         32'h0000_030C: return 32'h0000_006F; // jal
         32'h0000_0310: return 32'h0000_0063; // beq
         32'h0000_0314: return 32'h0000_2023; // sw
         default:       return a;
      endcase
   endfunction

   function automatic logic exp_ill(input logic [31:0] w);
      logic [6:0] op;
      op = w[6:0];
      if (!ILL_EN) return 1'b0;
      return !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b1100011 || op == 7'b1101111);
   endfunction

   // Memory model: data is valid exactly one cycle after the request.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic sb_reload(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 128; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
      check({tag, "_imem_addr"}, imem_addr, 32'd0);
      check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, "_instr"}, instr, 32'd0);
      check({tag, "_instr_pc"}, instr_pc, 32'd0);
      check({tag, "_instr_illegal"}, {31'd0, instr_illegal}, 32'd0);
   endtask

   // Scoreboard: the head must always be the next expected PC; pop on handshake.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (imem_req) check("imem_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
         if (instr_valid && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL sb_underrun: got instr_pc %h expected none", instr_pc);
            end else begin
               check("sb_pc", instr_pc, exp_q[0]);
               check("sb_instr", instr, mem_word(exp_q[0]));
               check("sb_illegal", {31'd0, instr_illegal}, {31'd0, exp_ill(mem_word(exp_q[0]))});
               if (instr_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive_redirect(input logic [31:0] t);
      redirect_valid = 1'b1;
      redirect_pc    = t;
      instr_ready    = 1'b1;
      sb_reload({t[31:2], 2'b00});
   endtask

   task automatic finish_redirect(input vec_t v);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      #1;
      check("rd_flushed", {31'd0, instr_valid}, 32'd0);
      check("rd_req", {31'd0, imem_req}, 32'd1);
      check("rd_addr", imem_addr, v.exp_pc);
      @(posedge clk); #1;
      check("rd_wait", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
      check("rd_valid", {31'd0, instr_valid}, 32'd1);
      check("rd_pc", instr_pc, v.exp_pc);
      check("rd_instr", instr, v.exp_word);
      check("rd_illegal", {31'd0, instr_illegal}, {31'd0, (ILL_EN ? v.exp_ill : 1'b0)});
   endtask

   initial begin
      vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 1'b1, 1'b0};
      vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0200, 1'b1, 1'b1};
      vecs[2] = '{32'h0000_0300, 32'h0000_0300, 32'h0000_0013, 1'b1, 1'b0};
      vecs[3] = '{32'h0000_0304, 32'h0000_0304, 32'h00B5_0533, 1'b0, 1'b0};
      vecs[4] = '{32'h0000_030B, 32'h0000_0308, 32'h0000_2003, 1'b0, 1'b1};
      vecs[5] = '{32'h0000_030C, 32'h0000_030C, 32'h0000_006F, 1'b0, 1'b0};
      vecs[6] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1, 1'b0};
      vecs[7] = '{32'h0000_0311, 32'h0000_0310, 32'h0000_0063, 1'b0, 1'b1};
      bb_vec  = '{32'h0000_0600, 32'h0000_0600, 32'h0000_0600, 1'b1, 1'b0};

      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      instr_ready    = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");

      // Release and stream with decode always ready.
      rst_n = 1'b1;
      sb_reload(32'd0);
      mon_en      = 1'b1;
      instr_ready = 1'b1;
      #1;
      check("rel_req", {31'd0, imem_req}, 32'd1);
      check("rel_addr", imem_addr, 32'd0);
      @(posedge clk); #1;
      check("first_valid_early", {31'd0, instr_valid}, 32'd0);
      check("addr_e1", imem_addr, 32'd4);
      @(posedge clk); #1;
      check("first_valid", {31'd0, instr_valid}, 32'd1);
      check("first_pc", instr_pc, 32'd0);
      for (int k = 2; k < 8; k++) begin
         check("stream_valid", {31'd0, instr_valid}, 32'd1);
         check("stream_addr", imem_addr, 32'(4 * k));
         @(posedge clk); #1;
      end

      // Backpressure: buffer fills, requests stop, head frozen.
      instr_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
      end
      check("stall_no_req", {31'd0, imem_req}, 32'd0);
      instr_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Reset asserted mid-stream: outputs return to reset values at once.
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb_reload(32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("inflight_setup_req", {31'd0, imem_req}, 32'd1);
      check("inflight_setup_addr", imem_addr, 32'h8);
      @(posedge clk); #1;
      // Fetch of 0x8 is outstanding now; redirect must discard it.
      drive_redirect(32'h0000_0100);
      finish_redirect(vecs[0]);
      repeat (4) @(posedge clk);
      #1;

      // Table of redirect targets, each followed by a short stream.
      foreach (vecs[i]) begin
         drive_redirect(vecs[i].target);
         finish_redirect(vecs[i]);
         for (int c = 0; c < 10; c++) begin
            instr_ready = vecs[i].rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
            @(posedge clk); #1;
         end
         instr_ready = 1'b1;
      end

      // Back-to-back redirects: the last one wins, no request in between.
      drive_redirect(32'h0000_0500);
      @(posedge clk); #1;
      drive_redirect(32'h0000_0600);
      #1;
      check("bb_no_req", {31'd0, imem_req}, 32'd0);
      finish_redirect(bb_vec);
      repeat (6) @(posedge clk);
      #1;

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
